// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, size codes and lane-mask helpers for the load/store unit
package lsu_pkg;

  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    RESP
  } lsu_state_t;

  typedef struct packed {
    logic                  write;
    logic [1:0]            size;
    logic                  is_signed;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
  } lsu_req_t;

  // Byte lanes touched across the two-word window; an invalid size touches nothing.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      SIZE_WORD: base = 8'h0F;
      SIZE_HALF: base = 8'h03;
      SIZE_BYTE: base = 8'h01;
      default:   base = 8'h00;
    endcase
    return base << off;
  endfunction

  // Address not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_WORD: return off != 2'b00;
      SIZE_HALF: return off[0];
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - word-addressed request/grant/response data-memory bus
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - merge two beat words, shift to the access offset, then extend
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] beat0,
  input  logic [31:0] beat1,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);
  logic [31:0] low;

  // Beat 1 sits above beat 0, so a right shift brings the addressed byte to lane 0.
  assign low = 32'({beat1, beat0} >> {off, 3'b000});

  // Sign- or zero-extend from the access size.
  always_comb begin
    data = low;
    case (size)
      SIZE_HALF: data = {{16{is_signed & low[15]}}, low[15:0]};
      SIZE_BYTE: data = {{24{is_signed & low[7]}}, low[7:0]};
      default:   data = low;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - one-outstanding load/store unit; LSU_MISALIGNED_EN enables word-crossing accesses
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  load_store_unit_if.master mem
);
  lsu_state_t        state_q, state_d;
  lsu_req_t          req_in, req_q, src;
  logic              err_q, accept, legal, hi, load_beat, two_beat;
  logic [7:0]        mask;
  logic [63:0]       wsh;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1, aligned;
  logic              we_q;

  assign req_in = {req_write, req_size, req_signed, req_addr, req_wdata};
  assign accept = (state_q == IDLE) && req_valid;

`ifdef LSU_MISALIGNED_EN
  logic [DATA_W-1:0] rdata1_q;
  assign legal    = (req_size != 2'b11);
  assign two_beat = |mask[7:4];
  assign rdata1   = rdata1_q;
`else
  assign legal    = (req_size != 2'b11) && !misaligned(req_size, req_addr[1:0]);
  assign two_beat = 1'b0;
  assign rdata1   = '0;
`endif

  // Beat parameters come from the incoming request in IDLE and from the held request afterwards.
  assign src  = (state_q == IDLE) ? req_in : req_q;
  assign hi   = (state_q != IDLE);
  assign mask = lane_mask(src.size, src.addr[1:0]);
  assign wsh  = {32'b0, src.wdata} << {src.addr[1:0], 3'b000};

  assign load_beat = (accept && legal) ||
                     ((state_q == WAIT0) && mem.mem_rvalid && two_beat);

  // State register; async reset drops mem_req immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = legal ? REQ0 : RESP;
      end
      REQ0:  if (mem.mem_gnt) state_d = WAIT0;
      WAIT0: if (mem.mem_rvalid) state_d = two_beat ? REQ1 : RESP;
`ifdef LSU_MISALIGNED_EN
      REQ1:  if (mem.mem_gnt) state_d = WAIT1;
      WAIT1: if (mem.mem_rvalid) state_d = RESP;
`endif
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !req_q.write) resp_rdata = aligned;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, registered bus beat and beat 0 read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q    <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata0_q <= '0;
    end else begin
      if (accept) begin
        req_q    <= req_in;
        err_q    <= !legal;
        rdata0_q <= '0;
      end
      if (load_beat) begin
        addr_q  <= ADDR_W'({src.addr[31:2], 2'b00} + (hi ? 32'd4 : 32'd0));
        be_q    <= hi ? mask[7:4] : mask[3:0];
        wdata_q <= hi ? wsh[63:32] : wsh[31:0];
        we_q    <= src.write;
      end
      if ((state_q == WAIT0) && mem.mem_rvalid) rdata0_q <= mem.mem_rdata;
    end
  end

`ifdef LSU_MISALIGNED_EN
  // Upper merge word for word-crossing loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   rdata1_q <= '0;
    else if (accept)                             rdata1_q <= '0;
    else if ((state_q == WAIT1) && mem.mem_rvalid) rdata1_q <= mem.mem_rdata;
  end
`endif

  assign mem.mem_req   = (state_q == REQ0) || (state_q == REQ1);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

  lsu_load_align u_align (
    .beat0     (rdata0_q),
    .beat1     (rdata1),
    .off       (req_q.addr[1:0]),
    .size      (req_q.size),
    .is_signed (req_q.is_signed),
    .data      (aligned)
  );
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  int          total = 0;
  int          bad = 0;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request for one cycle; afterwards we sit at the negedge of cycle N+1.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    check("req_ready_before_issue", req_ready, 1);
    step();
    req_valid = 1'b0;
  endtask

  // Serve one bus beat with an optional grant delay.
  task automatic beat(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                      input logic ewe, input logic [31:0] ewd, input int gd,
                      input logic [31:0] rd);
    int n;
    n = 0;
    while (!bus.mem_req && n < 8) begin step(); n++; end
    check({tag, "_req"}, bus.mem_req, 1);
    check({tag, "_addr"}, bus.mem_addr, ea);
    check({tag, "_be"}, bus.mem_be, ebe);
    check({tag, "_we"}, bus.mem_we, ewe);
    check({tag, "_wdata"}, bus.mem_wdata, ewd);
    for (int i = 0; i < gd; i++) begin
      bus.mem_gnt = 1'b0;
      step();
      check({tag, "_hold_req"}, bus.mem_req, 1);
      check({tag, "_hold_addr"}, bus.mem_addr, ea);
      check({tag, "_hold_be"}, bus.mem_be, ebe);
      check({tag, "_hold_wdata"}, bus.mem_wdata, ewd);
    end
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    check({tag, "_req_drop"}, bus.mem_req, 0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = rd;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic finish_resp(input string tag, input logic [31:0] er, input logic ee);
    check({tag, "_resp_valid"}, resp_valid, 1);
    check({tag, "_resp_rdata"}, resp_rdata, er);
    check({tag, "_resp_err"}, resp_err, ee);
    step();
    check({tag, "_resp_pulse"}, resp_valid, 0);
    check({tag, "_ready_again"}, req_ready, 1);
  endtask

  task automatic err_resp(input string tag);
    check({tag, "_no_mem_req"}, bus.mem_req, 0);
    finish_resp(tag, 32'h0, 1'b1);
    check({tag, "_no_mem_req_after"}, bus.mem_req, 0);
  endtask

  initial begin
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    step(); step();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_be", bus.mem_be, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    reset = 1'b0;

    // LB signed at 0x1003; also checks single-beat latency (req at N+1, resp at N+3, ready at N+4).
    issue(1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'h0);
    check("lb_lat_req_n1", bus.mem_req, 1);
    beat("lb", 32'h0000_1000, 4'b1000, 1'b0, 32'h0, 0, 32'h80FF_1234);
    finish_resp("lb", 32'hFFFF_FF80, 1'b0);

    // LBU at 0x1003
    issue(1'b0, 2'b10, 1'b0, 32'h0000_1003, 32'h0);
    beat("lbu", 32'h0000_1000, 4'b1000, 1'b0, 32'h0, 0, 32'h80FF_1234);
    finish_resp("lbu", 32'h0000_0080, 1'b0);

    // LHU at 0x2002
    issue(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0);
    beat("lhu", 32'h0000_2000, 4'b1100, 1'b0, 32'h0, 0, 32'hBEEF_0000);
    finish_resp("lhu", 32'h0000_BEEF, 1'b0);

    // LH signed at 0x7000, low half negative
    issue(1'b0, 2'b01, 1'b1, 32'h0000_7000, 32'h0);
    beat("lh", 32'h0000_7000, 4'b0011, 1'b0, 32'h0, 0, 32'h1234_8001);
    finish_resp("lh", 32'hFFFF_8001, 1'b0);

    // SB at 0x3001
    issue(1'b1, 2'b10, 1'b0, 32'h0000_3001, 32'h0000_00AB);
    beat("sb", 32'h0000_3000, 4'b0010, 1'b1, 32'h0000_AB00, 0, 32'h1234_5678);
    finish_resp("sb", 32'h0, 1'b0);

    // SW at 0x3000
    issue(1'b1, 2'b00, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF);
    beat("sw", 32'h0000_3000, 4'b1111, 1'b1, 32'hDEAD_BEEF, 0, 32'h1234_5678);
    finish_resp("sw", 32'h0, 1'b0);

    // Misaligned LW at 0x4002
    issue(1'b0, 2'b00, 1'b0, 32'h0000_4002, 32'h0);
`ifdef LSU_MISALIGNED_EN
    beat("lw_mis0", 32'h0000_4000, 4'b1100, 1'b0, 32'h0, 0, 32'h5566_7788);
    beat("lw_mis1", 32'h0000_4004, 4'b0011, 1'b0, 32'h0, 0, 32'h1122_3344);
    finish_resp("lw_mis", 32'h3344_5566, 1'b0);

    // Word-crossing half store at the top of memory wraps to address 0
    issue(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_CDEF);
    beat("sh_wrap0", 32'hFFFF_FFFC, 4'b1000, 1'b1, 32'hEF00_0000, 0, 32'h0);
    beat("sh_wrap1", 32'h0000_0000, 4'b0001, 1'b1, 32'h0000_00CD, 0, 32'h0);
    finish_resp("sh_wrap", 32'h0, 1'b0);
`else
    err_resp("lw_mis");

    // Misaligned half
    issue(1'b0, 2'b01, 1'b1, 32'h0000_7001, 32'h0);
    err_resp("lh_mis");
`endif

    // Invalid size -> error at N+1, no bus activity
    issue(1'b0, 2'b11, 1'b0, 32'h0000_5000, 32'h0);
    err_resp("size11");

    // Aligned LW with grant delayed 3 cycles
    issue(1'b0, 2'b00, 1'b0, 32'h0000_6000, 32'h0);
    beat("lw_gd", 32'h0000_6000, 4'b1111, 1'b0, 32'h0, 3, 32'hCAFE_F00D);
    finish_resp("lw_gd", 32'hCAFE_F00D, 1'b0);

    // Reset during WAIT0, then a stale rvalid
    issue(1'b0, 2'b00, 1'b0, 32'h0000_8000, 32'h0);
    check("rst_mid_req", bus.mem_req, 1);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_mem_req", bus.mem_req, 0);
    check("rst_mid_ready", req_ready, 1);
    step();
    reset = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      check("stale_no_resp", resp_valid, 0);
      check("stale_ready", req_ready, 1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
